// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Brief    : Memory-access pipeline stage. Waits for data SRAM responses of
//             loads, aligns/merges load data (LW/LH/LB/LWL/LWR), forwards
//             results, exceptions and CP0 fields to write-back, and discards
//             responses belonging to loads killed by a flush.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 125,
    parameter int MS_TO_WS_BUS_WD = 85
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       data_sram_data_ok,
    input  logic                       ex_from_ws,
    output logic                       ex_from_ms,
    output logic [31:0]                ms_forward,
    output logic                       ms_load_pending,
    output logic                       ms_res_from_cp0_h
);

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic [31:0]                r_rdata_buf;
    logic                       r_buf_valid;
    logic                       r_cancel;

    // Field decode of the registered execute-to-memory bus
    logic        w_eret, w_bd, w_mtc0_we, w_ex, w_res_from_cp0;
    logic [4:0]  w_cp0_addr, w_excode, w_dest;
    logic        w_lwl, w_lwr, w_ld_w, w_ld_h, w_ld_b, w_ld_sign, w_gr_we;
    logic [31:0] w_rt_value, w_alu_result, w_pc;
    logic [1:0]  w_offset;

    assign w_eret         = r_bus[124];
    assign w_bd           = r_bus[123];
    assign w_mtc0_we      = r_bus[122];
    assign w_cp0_addr     = r_bus[121:117];
    assign w_ex           = r_bus[116];
    assign w_excode       = r_bus[115:111];
    assign w_res_from_cp0 = r_bus[110];
    assign w_lwl          = r_bus[109];
    assign w_lwr          = r_bus[108];
    assign w_rt_value     = r_bus[107:76];
    assign w_ld_w         = r_bus[75];
    assign w_ld_h         = r_bus[74];
    assign w_ld_b         = r_bus[73];
    assign w_ld_sign      = r_bus[72];
    assign w_offset       = r_bus[71:70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_alu_result   = r_bus[63:32];
    assign w_pc           = r_bus[31:0];

    logic w_is_load, w_need_data, w_resp_live, w_resp_cur, w_ready_go, w_capture;

    assign w_is_load   = w_ld_w | w_ld_h | w_ld_b | w_lwl | w_lwr;
    assign w_need_data = r_ms_valid && w_is_load && !w_ex;
    // A response with cancel set belongs to a killed load and is dropped.
    assign w_resp_live = data_sram_data_ok && !r_cancel;
    assign w_resp_cur  = w_resp_live && w_need_data && !r_buf_valid;
    assign w_ready_go  = !w_need_data || r_buf_valid || w_resp_live;
    assign w_capture   = es_to_ms_valid && ms_allowin && !ex_from_ws;

    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;

    // Load data alignment and merge with rt for the unaligned forms
    logic [31:0] w_rd, w_load_val, w_final;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_rd   = r_buf_valid ? r_rdata_buf : data_sram_rdata;
    assign w_half = w_offset[1] ? w_rd[31:16] : w_rd[15:0];

    // Byte lane select by address offset
    always_comb begin
        w_byte = w_rd[7:0];
        case (w_offset)
            2'd0: w_byte = w_rd[7:0];
            2'd1: w_byte = w_rd[15:8];
            2'd2: w_byte = w_rd[23:16];
            2'd3: w_byte = w_rd[31:24];
            default: w_byte = w_rd[7:0];
        endcase
    end

    // Select the loaded value according to the load type
    always_comb begin
        w_load_val = w_rd;
        if (w_ld_h) begin
            w_load_val = {{16{w_ld_sign & w_half[15]}}, w_half};
        end else if (w_ld_b) begin
            w_load_val = {{24{w_ld_sign & w_byte[7]}}, w_byte};
        end else if (w_lwl) begin
            case (w_offset)
                2'd0: w_load_val = {w_rd[7:0],  w_rt_value[23:0]};
                2'd1: w_load_val = {w_rd[15:0], w_rt_value[15:0]};
                2'd2: w_load_val = {w_rd[23:0], w_rt_value[7:0]};
                default: w_load_val = w_rd;
            endcase
        end else if (w_lwr) begin
            case (w_offset)
                2'd0: w_load_val = w_rd;
                2'd1: w_load_val = {w_rt_value[31:24], w_rd[31:8]};
                2'd2: w_load_val = {w_rt_value[31:16], w_rd[31:16]};
                default: w_load_val = {w_rt_value[31:8], w_rd[31:24]};
            endcase
        end
    end

    // Excepting loads keep alu_result so write-back sees the bad address
    assign w_final = w_need_data ? w_load_val : w_alu_result;

    assign ms_to_ws_bus = {w_eret, w_bd, w_mtc0_we, w_cp0_addr, w_ex, w_excode,
                           w_res_from_cp0, w_gr_we, w_dest, w_final, w_pc};

    assign ex_from_ms        = r_ms_valid && (w_ex || w_eret);
    assign ms_forward        = w_final;
    assign ms_load_pending   = w_need_data && !w_ready_go;
    assign ms_res_from_cp0_h = r_ms_valid && w_res_from_cp0;

    // Stage valid: flush wins over capture of a new instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ex_from_ws) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    // Instruction payload register
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_bus <= es_to_ms_bus;
        end
    end

    // Hold load data that arrived while write-back was stalled
    always_ff @(posedge clk) begin
        if (reset || ex_from_ws || ms_allowin) begin
            r_buf_valid <= 1'b0;
        end else if (w_resp_cur && !ws_allowin) begin
            r_buf_valid <= 1'b1;
            r_rdata_buf <= data_sram_rdata;
        end
    end

    // Track one outstanding response owned by a flushed load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cancel <= 1'b0;
        end else if (ex_from_ws && w_need_data && !r_buf_valid && !w_resp_live) begin
            r_cancel <= 1'b1;
        end else if (data_sram_data_ok && r_cancel) begin
            r_cancel <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Self-checking bench for mem_stage: load alignment vectors plus
//             stall, flush/cancel and exception sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid;
    logic [124:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [84:0]  ms_to_ws_bus;
    logic [31:0]  data_sram_rdata;
    logic         data_sram_data_ok;
    logic         ex_from_ws;
    logic         ex_from_ms;
    logic [31:0]  ms_forward;
    logic         ms_load_pending;
    logic         ms_res_from_cp0_h;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.ES_TO_MS_BUS_WD(125), .MS_TO_WS_BUS_WD(85)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .ex_from_ws        (ex_from_ws),
        .ex_from_ms        (ex_from_ms),
        .ms_forward        (ms_forward),
        .ms_load_pending   (ms_load_pending),
        .ms_res_from_cp0_h (ms_res_from_cp0_h)
    );

    typedef struct {
        logic [124:0] bus;
        logic         is_load;
        logic [31:0]  rdata;
        logic [31:0]  exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [124:0] mk_bus(
        input logic ex, input logic [4:0] excode, input logic cp0,
        input logic lwl, input logic lwr, input logic [31:0] rt,
        input logic ldw, input logic ldh, input logic ldb, input logic sgn,
        input logic [1:0] off, input logic [31:0] alu, input logic [31:0] pc);
        logic [124:0] b;
        b = '0;
        b[116]     = ex;
        b[115:111] = excode;
        b[110]     = cp0;
        b[109]     = lwl;
        b[108]     = lwr;
        b[107:76]  = rt;
        b[75]      = ldw;
        b[74]      = ldh;
        b[73]      = ldb;
        b[72]      = sgn;
        b[71:70]   = off;
        b[69]      = 1'b1;
        b[68:64]   = 5'd3;
        b[63:32]   = alu;
        b[31:0]    = pc;
        return b;
    endfunction

    function automatic logic [124:0] lw_bus(input logic [31:0] pc);
        return mk_bus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                      2'd0, 32'h2000, pc);
    endfunction

    // Present an instruction for one cycle; returns at posedge+1 with it in MS
    task automatic issue(input logic [124:0] b);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    vec_t vecs[11];

    initial begin
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        data_sram_rdata = '0; data_sram_data_ok = 1'b0; ex_from_ws = 1'b0;

        //            ex  exc  cp0 lwl  lwr  rt            ldw  ldh  ldb  sgn  off
        vecs[0]  = '{mk_bus(0,0,0,0,0,32'h0,       1,0,0,0,2'd0,32'h1000,32'h100), 1, 32'h8899AABB, 32'h8899AABB};
        vecs[1]  = '{mk_bus(0,0,0,0,0,32'h0,       0,0,1,1,2'd3,32'h1003,32'h104), 1, 32'h80112233, 32'hFFFFFF80};
        vecs[2]  = '{mk_bus(0,0,0,0,0,32'h0,       0,1,0,0,2'd2,32'h1002,32'h108), 1, 32'h80112233, 32'h00008011};
        vecs[3]  = '{mk_bus(0,0,0,0,0,32'h0,       0,1,0,1,2'd0,32'h1000,32'h10C), 1, 32'h0000F00F, 32'hFFFFF00F};
        vecs[4]  = '{mk_bus(0,0,0,0,0,32'h0,       0,0,1,0,2'd1,32'h1001,32'h110), 1, 32'h0000A500, 32'h000000A5};
        vecs[5]  = '{mk_bus(0,0,0,1,0,32'h11223344,0,0,0,0,2'd1,32'h1001,32'h114), 1, 32'hAABBCCDD, 32'hCCDD3344};
        vecs[6]  = '{mk_bus(0,0,0,0,1,32'h11223344,0,0,0,0,2'd2,32'h1002,32'h118), 1, 32'hAABBCCDD, 32'h1122AABB};
        vecs[7]  = '{mk_bus(0,0,0,1,0,32'h11223344,0,0,0,0,2'd0,32'h1000,32'h11C), 1, 32'hAABBCCDD, 32'hDD223344};
        vecs[8]  = '{mk_bus(0,0,0,0,1,32'h11223344,0,0,0,0,2'd3,32'h1003,32'h120), 1, 32'hAABBCCDD, 32'h112233AA};
        vecs[9]  = '{mk_bus(0,0,0,0,0,32'h0,       0,0,1,1,2'd0,32'h1000,32'h124), 1, 32'h0000007F, 32'h0000007F};
        vecs[10] = '{mk_bus(0,0,0,0,0,32'h0,       0,0,0,0,2'd2,32'hCAFEBABE,32'h128), 0, 32'h0, 32'hCAFEBABE};

        step(); step();
        reset = 1'b0;
        #1;
        chk("reset_allowin", {31'b0, ms_allowin}, 32'd1);
        chk("reset_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        chk("reset_ex", {31'b0, ex_from_ms}, 32'd0);
        chk("reset_pending", {31'b0, ms_load_pending}, 32'd0);
        chk("reset_cp0", {31'b0, ms_res_from_cp0_h}, 32'd0);

        // Single-cycle vectors: response in the first MS cycle, no stall
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].bus);
            data_sram_data_ok = vecs[i].is_load;
            data_sram_rdata   = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_valid", i), {31'b0, ms_to_ws_valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), ms_to_ws_bus[63:32], vecs[i].exp);
            chk($sformatf("vec%0d_fwd", i), ms_forward, vecs[i].exp);
            chk($sformatf("vec%0d_pending", i), {31'b0, ms_load_pending}, 32'd0);
            chk($sformatf("vec%0d_pc", i), ms_to_ws_bus[31:0], vecs[i].bus[31:0]);
            step();
            data_sram_data_ok = 1'b0;
        end
        #1;
        chk("idle_valid", {31'b0, ms_to_ws_valid}, 32'd0);

        // Delayed response then write-back stall
        issue(lw_bus(32'h200));
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("wait%0d_pending", c), {31'b0, ms_load_pending}, 32'd1);
            chk($sformatf("wait%0d_valid", c), {31'b0, ms_to_ws_valid}, 32'd0);
            chk($sformatf("wait%0d_allowin", c), {31'b0, ms_allowin}, 32'd0);
            step();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55667788; ws_allowin = 1'b0;
        #1;
        chk("arrive_pending", {31'b0, ms_load_pending}, 32'd0);
        chk("arrive_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("arrive_allowin", {31'b0, ms_allowin}, 32'd0);
        step();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        #1;
        chk("held_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("held_result", ms_to_ws_bus[63:32], 32'h55667788);
        step();
        ws_allowin = 1'b1;
        #1;
        chk("release_result", ms_to_ws_bus[63:32], 32'h55667788);
        chk("release_allowin", {31'b0, ms_allowin}, 32'd1);
        step();
        chk("release_gone", {31'b0, ms_to_ws_valid}, 32'd0);

        // Flush while a load waits; its late response must be discarded
        issue(lw_bus(32'h300));
        ex_from_ws = 1'b1;
        #1;
        chk("flush_pending", {31'b0, ms_load_pending}, 32'd1);
        step();
        ex_from_ws = 1'b0;
        chk("flush_killed", {31'b0, ms_to_ws_valid}, 32'd0);
        issue(lw_bus(32'h304));
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD0000;
        #1;
        chk("stale_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        chk("stale_pending", {31'b0, ms_load_pending}, 32'd1);
        step();
        data_sram_rdata = 32'h12345678;
        #1;
        chk("fresh_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("fresh_result", ms_to_ws_bus[63:32], 32'h12345678);
        chk("fresh_pc", ms_to_ws_bus[31:0], 32'h304);
        step();
        data_sram_data_ok = 1'b0;

        // Flush coincident with the response: no cancel left behind
        issue(lw_bus(32'h400));
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111; ex_from_ws = 1'b1;
        step();
        data_sram_data_ok = 1'b0; ex_from_ws = 1'b0;
        issue(lw_bus(32'h404));
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BADF00D;
        #1;
        chk("coinc_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("coinc_result", ms_to_ws_bus[63:32], 32'h0BADF00D);
        step();
        data_sram_data_ok = 1'b0;

        // Flush beats capture of an incoming instruction
        es_to_ms_valid = 1'b1; es_to_ms_bus = lw_bus(32'h500); ex_from_ws = 1'b1;
        step();
        es_to_ms_valid = 1'b0; ex_from_ws = 1'b0;
        chk("prio_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        chk("prio_pending", {31'b0, ms_load_pending}, 32'd0);

        // Excepting load passes the bad address without waiting
        issue(mk_bus(1, 5'h04, 0, 0, 0, 32'h0, 1, 0, 0, 0, 2'd2, 32'h1002, 32'h600));
        #1;
        chk("exc_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("exc_ex_from_ms", {31'b0, ex_from_ms}, 32'd1);
        chk("exc_result", ms_to_ws_bus[63:32], 32'h00001002);
        chk("exc_code", {27'b0, ms_to_ws_bus[75:71]}, 32'h4);
        chk("exc_pending", {31'b0, ms_load_pending}, 32'd0);
        step();

        // CP0 read flag
        issue(mk_bus(0, 5'd0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h700));
        #1;
        chk("cp0_h", {31'b0, ms_res_from_cp0_h}, 32'd1);
        chk("cp0_bus", {31'b0, ms_to_ws_bus[70]}, 32'd1);
        step();

        // Reset during a wait clears everything
        issue(lw_bus(32'h800));
        ex_from_ws = 1'b1;
        step();
        ex_from_ws = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        issue(lw_bus(32'h804));
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA5A5A5A5;
        #1;
        chk("rst_cancel_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("rst_cancel_result", ms_to_ws_bus[63:32], 32'hA5A5A5A5);
        step();
        data_sram_data_ok = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
